// File: rtl/strb_gen_pkg.sv
// Shared types and helpers for the multi-channel strobe generator.
package strb_gen_pkg;

  // Default divisor width used by div_t and eff_div.
  localparam int unsigned DIV_W_DEF = 8;

  // Smallest meaningful divisor; 0 is treated the same as this.
  localparam int unsigned DIV_MIN = 1;

  typedef logic [DIV_W_DEF-1:0] div_t;

  // Effective divisor: max(d, DIV_MIN).
  function automatic div_t eff_div(input div_t d);
    if (d < div_t'(DIV_MIN)) begin
      return div_t'(DIV_MIN);
    end else begin
      return d;
    end
  endfunction

endpackage

// File: rtl/strb_gen_ch.sv
// One strobe channel: counter, active/pending divisor, registered strobe.
// Optional toggle output when STRB_GEN_TOGGLE_OUT_EN is defined.
module strb_gen_ch
  import strb_gen_pkg::*;
#(
  parameter int unsigned DIV_W   = 8,
  parameter int unsigned DIV_RST = 2
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             we_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             pend_o,
  output logic             strb_o
`ifdef STRB_GEN_TOGGLE_OUT_EN
  ,
  output logic             tgl_o
`endif
);

  localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};

  logic [DIV_W-1:0] cnt_r;
  logic [DIV_W-1:0] div_act_r;
  logic [DIV_W-1:0] div_pend_r;
  logic             pend_r;
  logic             strb_r;
  logic [DIV_W-1:0] deff_s;
  logic [DIV_W-1:0] last_s;
  logic             wrap_s;
  logic             apply_s;

  if (DIV_W == DIV_W_DEF) begin : g_eff_pkg
    // Effective divisor through the shared helper.
    always_comb deff_s = DIV_W'(eff_div(div_t'(div_act_r)));
  end else begin : g_eff_local
    // Effective divisor for non-default widths.
    always_comb deff_s = (div_act_r == DIV_ZERO) ? DIV_W'(DIV_MIN) : div_act_r;
  end

  // Terminal-count and divisor-apply decisions for this cycle.
  always_comb begin
    last_s  = deff_s - DIV_ONE;
    wrap_s  = 1'b0;
    apply_s = 1'b0;
    // >= rather than == so a counter held above a freshly shrunk divisor
    // wraps on the next enabled cycle instead of running to overflow.
    if (cnt_r >= last_s) begin
      wrap_s = 1'b1;
    end else begin
      wrap_s = 1'b0;
    end
    if (clr_i || !en_i || wrap_s) begin
      apply_s = 1'b1;
    end else begin
      apply_s = 1'b0;
    end
  end

  // Counter and strobe register, clear has priority over enable.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cnt_r  <= DIV_ZERO;
      strb_r <= 1'b0;
    end else if (clr_i) begin
      cnt_r  <= DIV_ZERO;
      strb_r <= 1'b0;
    end else if (!en_i) begin
      cnt_r  <= cnt_r;
      strb_r <= 1'b0;
    end else if (wrap_s) begin
      cnt_r  <= DIV_ZERO;
      strb_r <= 1'b1;
    end else begin
      cnt_r  <= cnt_r + DIV_ONE;
      strb_r <= 1'b0;
    end
  end

  // Active/pending divisor: a write landing on an apply edge queues behind
  // the value being applied.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      div_act_r  <= DIV_W'(DIV_RST);
      div_pend_r <= DIV_ZERO;
      pend_r     <= 1'b0;
    end else begin
      if (apply_s && pend_r) begin
        div_act_r <= div_pend_r;
      end else begin
        div_act_r <= div_act_r;
      end
      if (we_i) begin
        div_pend_r <= div_i;
        pend_r     <= 1'b1;
      end else if (apply_s) begin
        div_pend_r <= div_pend_r;
        pend_r     <= 1'b0;
      end else begin
        div_pend_r <= div_pend_r;
        pend_r     <= pend_r;
      end
    end
  end

`ifdef STRB_GEN_TOGGLE_OUT_EN
  logic tgl_r;

  // Square wave that flips whenever a strobe is being issued.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      tgl_r <= 1'b0;
    end else if (clr_i) begin
      tgl_r <= 1'b0;
    end else if (en_i && wrap_s) begin
      tgl_r <= ~tgl_r;
    end else begin
      tgl_r <= tgl_r;
    end
  end

  assign tgl_o = tgl_r;
`endif

  assign pend_o = pend_r;
  assign strb_o = strb_r;

endmodule

// File: rtl/strb_gen_multi.sv
// Multi-channel runtime-programmable strobe generator (top level).
// Optional feature macro: STRB_GEN_TOGGLE_OUT_EN adds the tgl_o port.
module strb_gen_multi
  import strb_gen_pkg::*;
#(
  parameter int unsigned CH_NUM  = 2,
  parameter int unsigned DIV_W   = 8,
  parameter int unsigned DIV_RST = 2,
  localparam int unsigned CH_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic [CH_NUM-1:0] en_i,
  input  logic [CH_NUM-1:0] clr_i,
  input  logic              div_we_i,
  input  logic [CH_W-1:0]   div_ch_i,
  input  logic [DIV_W-1:0]  div_i,
  output logic [CH_NUM-1:0] div_pend_o,
  output logic [CH_NUM-1:0] strb_o
`ifdef STRB_GEN_TOGGLE_OUT_EN
  ,
  output logic [CH_NUM-1:0] tgl_o
`endif
);

  logic [CH_NUM-1:0] ch_we_s;

  // Decode the shared write port; out-of-range channel numbers match nothing.
  always_comb begin
    ch_we_s = {CH_NUM{1'b0}};
    for (int i = 0; i < int'(CH_NUM); i++) begin
      if (div_we_i && (div_ch_i == CH_W'(i))) begin
        ch_we_s[i] = 1'b1;
      end else begin
        ch_we_s[i] = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < int'(CH_NUM); g++) begin : g_ch
    strb_gen_ch #(
      .DIV_W   (DIV_W),
      .DIV_RST (DIV_RST)
    ) u_ch (
      .clk_i  (clk_i),
      .arst_i (arst_i),
      .en_i   (en_i[g]),
      .clr_i  (clr_i[g]),
      .we_i   (ch_we_s[g]),
      .div_i  (div_i),
      .pend_o (div_pend_o[g]),
      .strb_o (strb_o[g])
`ifdef STRB_GEN_TOGGLE_OUT_EN
      ,
      .tgl_o  (tgl_o[g])
`endif
    );
  end

endmodule
